kmac_bytepad: RTL and testbench

Streaming bytepad(X, w) stage for the KMAC front end. It emits left_encode(w), then passes the already-encoded byte string X through unchanged, then appends zero bytes until the total length is a multiple of w. It sits directly downstream of the string-encoding stage, which supplies X (encode_string(N) || encode_string(S)), and upstream of the Keccak absorb buffer.

---
 rtl/kmac_bytepad.sv | 137 +++++++++++++
 tb/tb_kmac_bytepad.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kmac_bytepad.sv
// kmac_bytepad
//   Streaming bytepad(X, w) stage. Emits left_encode(w) = {0x01, w}, passes
//   the already-encoded string X straight through, then appends 0x00 bytes
//   until the output length is a multiple of w (RATE_BYTES).
//
// Handshake: a byte moves on a channel when valid && ready are both high at
//   a rising clock edge. A producer holding valid high with ready low keeps
//   its data (and last) stable until the transfer happens. valid never
//   depends on ready on the output side except in DATA, where out_valid is
//   the upstream in_valid and in_ready is the downstream out_ready.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, x_empty      begin an operation (sampled in IDLE); X has no bytes
//   in_data/valid/last  byte stream of X, in_ready back-pressure
//   out_data/valid/last padded byte stream, out_ready back-pressure
//   busy                state is not IDLE
//   done                one-cycle pulse after the out_last transfer
//   dbg_state           current FSM state for checkers
module kmac_bytepad #(
    parameter int unsigned RATE_BYTES = 168
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       x_empty,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready,
    output logic       busy,
    output logic       done,
    output logic [2:0] dbg_state
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PFX0 = 3'd1;
    localparam logic [2:0] S_PFX1 = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_PAD  = 3'd4;

    localparam logic [7:0] RATE_B   = 8'(RATE_BYTES);
    localparam logic [7:0] LAST_POS = 8'(RATE_BYTES - 1);

    logic [2:0] state;
    logic [7:0] pos;
    logic       x_empty_q;
    logic       done_q;

    logic       pos_wrap;
    logic       out_xfer;

    // pos is the index within the current w-byte block of the byte being
    // presented; the byte at LAST_POS closes a block.
    assign pos_wrap = (pos == LAST_POS);
    assign out_xfer = out_valid && out_ready;

    always_comb begin
        out_data  = 8'h00;
        out_valid = 1'b0;
        out_last  = 1'b0;
        in_ready  = 1'b0;
        case (state)
            S_PFX0: begin
                out_data  = 8'h01;
                out_valid = 1'b1;
            end
            S_PFX1: begin
                out_data  = RATE_B;
                out_valid = 1'b1;
                out_last  = x_empty_q && pos_wrap;
            end
            S_DATA: begin
                out_data  = in_data;
                out_valid = in_valid;
                in_ready  = out_ready;
                out_last  = in_valid && in_last && pos_wrap;
            end
            S_PAD: begin
                out_valid = 1'b1;
                out_last  = pos_wrap;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pos       <= 8'd0;
            x_empty_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= out_xfer && out_last;
            if (out_xfer) begin
                pos <= pos_wrap ? 8'd0 : pos + 8'd1;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pos       <= 8'd0;
                        x_empty_q <= x_empty;
                        state     <= S_PFX0;
                    end
                end
                S_PFX0: begin
                    if (out_xfer) state <= S_PFX1;
                end
                S_PFX1: begin
                    if (out_xfer) begin
                        if (!x_empty_q)    state <= S_DATA;
                        else if (pos_wrap) state <= S_IDLE;
                        else               state <= S_PAD;
                    end
                end
                S_DATA: begin
                    if (out_xfer && in_last) begin
                        state <= pos_wrap ? S_IDLE : S_PAD;
                    end
                end
                S_PAD: begin
                    if (out_xfer && pos_wrap) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign done      = done_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_kmac_bytepad.sv
// tb_kmac_bytepad
//   Self-checking bench for kmac_bytepad. Two instances: w=168 and w=1,
//   selected by sel. Expected output is built from the bytepad definition:
//   {01, w} ++ X ++ zeros up to a multiple of w.
module tb_kmac_bytepad;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       x_empty;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       out_ready;
  logic       sel;

  logic       ir0, ov0, ol0, bz0, dn0;
  logic [7:0] od0;
  logic [2:0] st0;
  logic       ir1, ov1, ol1, bz1, dn1;
  logic [7:0] od1;
  logic [2:0] st1;

  logic       o_ir, o_ov, o_ol, o_bz, o_dn;
  logic [7:0] o_od;

  int checks;
  int errors;

  logic [7:0] x_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  kmac_bytepad #(.RATE_BYTES(168)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start && !sel), .x_empty(x_empty),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(ir0),
    .out_data(od0), .out_valid(ov0), .out_last(ol0), .out_ready(out_ready),
    .busy(bz0), .done(dn0), .dbg_state(st0)
  );

  kmac_bytepad #(.RATE_BYTES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start && sel), .x_empty(x_empty),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(ir1),
    .out_data(od1), .out_valid(ov1), .out_last(ol1), .out_ready(out_ready),
    .busy(bz1), .done(dn1), .dbg_state(st1)
  );

  assign o_ir = sel ? ir1 : ir0;
  assign o_ov = sel ? ov1 : ov0;
  assign o_ol = sel ? ol1 : ol0;
  assign o_bz = sel ? bz1 : bz0;
  assign o_dn = sel ? dn1 : dn0;
  assign o_od = sel ? od1 : od0;

  // ---------------- reference model ----------------
  task automatic build_expected(input int w);
    exp_q = {};
    exp_q.push_back(8'h01);
    exp_q.push_back(8'(w));
    foreach (x_q[i]) exp_q.push_back(x_q[i]);
    while ((exp_q.size() % w) != 0) exp_q.push_back(8'h00);
  endtask

  // ---------------- driver + checker for one operation ----------------
  // Called at a point between edges; start is asserted for the next edge.
  // Returns in the done cycle (or the one after, if check_drop).
  task automatic run_op(input string name, input bit stall, input bit check_drop,
                        input bit check_ir);
    int  w, n, ptr, cyc, last_idx, ir_cnt, busy_cnt;
    bit  finished, pending, prev_stall, prev_last, coincide, exp_coincide;
    logic [7:0] prev_data;
    w = sel ? 1 : 168;
    n = x_q.size();
    build_expected(w);
    got_q = {};
    ptr = 0; cyc = 0; last_idx = -1; ir_cnt = 0; busy_cnt = 0;
    finished = 0; pending = 0; prev_stall = 0; prev_last = 0; prev_data = 8'h00;
    coincide = 0;
    exp_coincide = (n > 0) && (((2 + n) % w) == 0);

    start = 1'b1; x_empty = (n == 0); in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!finished && cyc < 3000) begin
      out_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (ptr < n) begin
        if (!pending) in_valid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
        in_data = x_q[ptr];
        in_last = (ptr == n - 1);
      end else begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = 8'($urandom);
        in_last  = 1'b1;
      end
      #1;
      if (prev_stall) begin
        checks++;
        if (o_ov !== 1'b1 || o_od !== prev_data || o_ol !== prev_last) begin
          errors++;
          $display("FAIL %s hold: valid=%b data=%h last=%b required valid=1 data=%h last=%b",
                   name, o_ov, o_od, o_ol, prev_data, prev_last);
        end
      end
      if (o_ir) ir_cnt++;
      if (o_bz) busy_cnt++;
      if (o_ov && out_ready) begin
        got_q.push_back(o_od);
        if (o_ol) begin
          last_idx = got_q.size() - 1;
          finished = 1;
          coincide = in_valid && o_ir && in_last && (ptr == n - 1);
        end
      end
      if (ptr < n && in_valid && o_ir) begin
        ptr++;
        pending = 0;
      end else begin
        pending = (ptr < n) && in_valid;
      end
      prev_stall = o_ov && !out_ready;
      prev_data  = o_od;
      prev_last  = o_ol;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;

    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL %s timeout: no out_last within %0d cycles, got %0d bytes", name, cyc, got_q.size());
    end
    #1;
    checks++;
    if (o_dn !== 1'b1 || o_bz !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse: done=%b busy=%b required done=1 busy=0", name, o_dn, o_bz);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s length: got %0d required %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s byte[%0d]: got %h required %h", name, i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (last_idx != exp_q.size() - 1) begin
      errors++;
      $display("FAIL %s last_index: got %0d required %0d", name, last_idx, exp_q.size() - 1);
    end
    checks++;
    if (coincide != exp_coincide) begin
      errors++;
      $display("FAIL %s last_with_in_last: got %b required %b", name, coincide, exp_coincide);
    end
    if (!stall) begin
      checks++;
      if (busy_cnt != exp_q.size()) begin
        errors++;
        $display("FAIL %s busy_cycles: got %0d required %0d", name, busy_cnt, exp_q.size());
      end
    end
    if (check_ir) begin
      checks++;
      if (ir_cnt != n) begin
        errors++;
        $display("FAIL %s in_ready_cycles: got %0d required %0d", name, ir_cnt, n);
      end
    end
    if (check_drop) begin
      @(negedge clk);
      #1;
      checks++;
      if (o_dn !== 1'b0) begin
        errors++;
        $display("FAIL %s done_drop: done=%b required 0", name, o_dn);
      end
    end
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (o_ov !== 1'b0 || o_ir !== 1'b0 || o_ol !== 1'b0 || o_bz !== 1'b0 ||
        o_dn !== 1'b0 || o_od !== 8'h00) begin
      errors++;
      $display("FAIL %s idle_outputs: valid=%b ready=%b last=%b busy=%b done=%b data=%h required all 0",
               name, o_ov, o_ir, o_ol, o_bz, o_dn, o_od);
    end
  endtask

  task automatic fill_random(input int n);
    x_q = {};
    for (int i = 0; i < n; i++) x_q.push_back(8'($urandom));
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    sel = 1'b0; rst_n = 1'b0; start = 1'b0; x_empty = 1'b0;
    in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check_idle_outputs("after_reset");
  endtask

  task automatic test_empty();
    x_q = {};
    run_op("empty", 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_short();
    x_q = {8'hAA, 8'hBB, 8'hCC};
    run_op("short", 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_exact_fit();
    x_q = {};
    for (int i = 0; i < 166; i++) x_q.push_back(8'(i));
    run_op("exact_fit", 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_one_over();
    fill_random(167);
    run_op("one_over", 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_backpressure();
    x_q = {8'hAA, 8'hBB, 8'hCC};
    run_op("bp_short", 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      fill_random($urandom_range(0, 400));
      run_op("bp_random", 1'b1, 1'b1, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    fill_random(10);
    run_op("b2b_first", 1'b0, 1'b0, 1'b1);
    fill_random(170);
    run_op("b2b_second", 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid();
    start = 1'b1; x_empty = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; in_data = 8'h77; in_last = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    checks++;
    if (o_ov !== 1'b1 || o_ir !== 1'b1 || o_od !== 8'h77) begin
      errors++;
      $display("FAIL reset_mid in_data: valid=%b ready=%b data=%h required 1 1 77", o_ov, o_ir, o_od);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("reset_mid_async");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_idle_outputs("reset_mid_no_resume");
    in_valid = 1'b0; in_last = 1'b0;
    fill_random(50);
    run_op("after_reset_mid", 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_rate1();
    sel = 1'b1;
    @(negedge clk);
    #1;
    check_idle_outputs("rate1_idle");
    x_q = {8'h5A};
    run_op("rate1_5a", 1'b0, 1'b1, 1'b1);
    x_q = {};
    run_op("rate1_empty", 1'b0, 1'b1, 1'b1);
    fill_random(20);
    run_op("rate1_bp", 1'b1, 1'b1, 1'b0);
    sel = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    @(negedge clk);
    test_empty();
    test_short();
    test_exact_fit();
    test_one_over();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_rate1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
